control_reproduccion: RTL and testbench

Playback sequencer for one song. Drives the note address generator through its `empiece`/`cuente` strobes and reads each note word from the synchronous song ROM at the generator's address. Holds each note for its encoded number of beats, then detects end-of-song from the generator's `termino` flag. Sits between the user controls (play/stop/pause) and the audio/video note consumers.

---
 rtl/control_reproduccion_pkg.sv | 24 ++
 rtl/control_reproduccion_divisor.sv | 32 +++
 rtl/control_reproduccion.sv | 120 ++++++++++++
 tb/tb_control_reproduccion.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_reproduccion_pkg.sv
// Shared widths, note-word layout and state encoding for the song playback sequencer.
package pkg_reproduccion;

    localparam int NOTE_W = 5;
    localparam int DUR_W  = 4;
    localparam int WORD_W = NOTE_W + DUR_W;

    // Note word layout in the song ROM: {dur, nota}
    localparam int NOTA_LSB = 0;
    localparam int NOTA_MSB = NOTE_W - 1;
    localparam int DUR_LSB  = NOTE_W;
    localparam int DUR_MSB  = NOTE_W + DUR_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_LOAD   = 3'd3,
        ST_PLAY   = 3'd4,
        ST_PAUSED = 3'd5,
        ST_STEP   = 3'd6
    } estado_t;

endpackage

// File: rtl/control_reproduccion_divisor.sv
// Prescaler counting 0..DIV-1 with synchronous clear and enable; ticks on the terminal count.
module divisor_pulso #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic ultimo,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] MAXIMO = CW'(DIV - 1);

    logic [CW-1:0] cuenta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cuenta <= '0;
        end else if (clear) begin
            cuenta <= '0;
        end else if (enable) begin
            cuenta <= (cuenta == MAXIMO) ? '0 : cuenta + 1'b1;
        end
    end

    // ultimo is independent of enable so the caller can gate enable on it
    assign ultimo = (cuenta == MAXIMO);
    assign tick   = enable & ultimo;

endmodule

// File: rtl/control_reproduccion.sv
// Playback sequencer: steps the address generator, latches ROM note words and times each note in beats.
module control_reproduccion
    import pkg_reproduccion::*;
#(
    parameter int ADDR_W   = 7,
    parameter int NOTE_W   = pkg_reproduccion::NOTE_W,
    parameter int DUR_W    = pkg_reproduccion::DUR_W,
    parameter int TICK_DIV = 12500000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    play,
    input  logic                    stop,
    input  logic                    pausa,
    input  logic                    repetir,
    input  logic                    termino,
    input  logic [DUR_W+NOTE_W-1:0] mem_data,
    output logic                    empiece,
    output logic                    cuente,
    output logic [NOTE_W-1:0]       nota,
    output logic                    nota_valida,
    output logic                    reproduciendo,
    output logic                    fin
);

    if (TICK_DIV < 2 || ADDR_W < 1) begin : g_param_check
        $error("control_reproduccion: TICK_DIV must be >= 2 and ADDR_W >= 1");
    end

    estado_t           estado, estado_sig;
    logic              fin_sig;
    logic [DUR_W-1:0]  dur_q;
    logic [DUR_W-1:0]  pulsos;
    logic              en_div, clr_div, ultimo, tick;

    // A pausa landing on the terminal count freezes the prescaler so that tick is replayed on resume
    assign en_div  = (estado == ST_PLAY) && !stop && !play && !(pausa && ultimo);
    assign clr_div = (estado == ST_LOAD);

    divisor_pulso #(
        .DIV (TICK_DIV)
    ) u_divisor (
        .clock  (clock),
        .reset  (reset),
        .clear  (clr_div),
        .enable (en_div),
        .ultimo (ultimo),
        .tick   (tick)
    );

    always_comb begin
        estado_sig = estado;
        fin_sig    = 1'b0;
        if (stop) begin
            estado_sig = ST_IDLE;
        end else if (play) begin
            estado_sig = ST_START;
        end else begin
            case (estado)
                ST_IDLE:   estado_sig = ST_IDLE;
                ST_START:  estado_sig = ST_WAIT;
                ST_WAIT: begin
                    if (termino) begin
                        if (repetir) begin
                            estado_sig = ST_START;
                        end else begin
                            estado_sig = ST_IDLE;
                            fin_sig    = 1'b1;
                        end
                    end else begin
                        estado_sig = ST_LOAD;
                    end
                end
                ST_LOAD:   estado_sig = ST_PLAY;
                ST_PLAY: begin
                    if (pausa) begin
                        estado_sig = ST_PAUSED;
                    end else if (tick && (pulsos == dur_q)) begin
                        estado_sig = ST_STEP;
                    end
                end
                ST_PAUSED: if (pausa) estado_sig = ST_PLAY;
                ST_STEP:   estado_sig = ST_WAIT;
                default:   estado_sig = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with the state they describe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= ST_IDLE;
            empiece       <= 1'b0;
            cuente        <= 1'b0;
            nota          <= '0;
            nota_valida   <= 1'b0;
            reproduciendo <= 1'b0;
            fin           <= 1'b0;
            dur_q         <= '0;
            pulsos        <= '0;
        end else begin
            estado        <= estado_sig;
            empiece       <= (estado_sig == ST_START);
            cuente        <= (estado_sig == ST_STEP);
            nota_valida   <= (estado_sig == ST_PLAY);
            reproduciendo <= (estado_sig != ST_IDLE);
            fin           <= fin_sig;
            if (estado == ST_LOAD && estado_sig == ST_PLAY) begin
                nota  <= mem_data[NOTE_W-1:0];
                dur_q <= mem_data[NOTE_W+DUR_W-1:NOTE_W];
            end
            if (estado == ST_LOAD) begin
                pulsos <= '0;
            end else if (tick && (pulsos != dur_q)) begin
                pulsos <= pulsos + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_reproduccion.sv
// Bench for control_reproduccion: address generator and 4-word ROM models plus a per-cycle expected trace.
module tb_control_reproduccion;

    localparam int ADDR_W   = 7;
    localparam int NOTE_W   = 5;
    localparam int DUR_W    = 4;
    localparam int TICK_DIV = 4;
    localparam int W        = NOTE_W + 5;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    play = 1'b0, stop = 1'b0, pausa = 1'b0, repetir = 1'b0;
    logic                    termino;
    logic [DUR_W+NOTE_W-1:0] mem_data;
    logic                    empiece, cuente, nota_valida, reproduciendo, fin;
    logic [NOTE_W-1:0]       nota;

    logic [ADDR_W-1:0]       direccion;
    logic [ADDR_W-1:0]       limite = '0;
    logic [DUR_W+NOTE_W-1:0] rom [0:3];

    logic [W-1:0]            exp_q [$];
    logic [NOTE_W-1:0]       cur_nota = '0;
    int                      total = 0;
    int                      passed = 0;
    int                      failed = 0;

    control_reproduccion #(
        .ADDR_W   (ADDR_W),
        .NOTE_W   (NOTE_W),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .play          (play),
        .stop          (stop),
        .pausa         (pausa),
        .repetir       (repetir),
        .termino       (termino),
        .mem_data      (mem_data),
        .empiece       (empiece),
        .cuente        (cuente),
        .nota          (nota),
        .nota_valida   (nota_valida),
        .reproduciendo (reproduciendo),
        .fin           (fin)
    );

    always #5 clock = ~clock;

    // Address generator and synchronous ROM, sharing the sequencer's reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            direccion <= '0;
            termino   <= 1'b0;
            mem_data  <= '0;
        end else begin
            mem_data <= rom[direccion[1:0]];
            if (empiece) begin
                direccion <= '0;
                termino   <= 1'b0;
            end else if (cuente) begin
                if (direccion == limite) begin
                    direccion <= '0;
                    termino   <= 1'b1;
                end else begin
                    direccion <= direccion + 1'b1;
                    termino   <= 1'b0;
                end
            end
        end
    end

    function automatic logic [W-1:0] outs();
        return {empiece, cuente, nota, nota_valida, reproduciendo, fin};
    endfunction

    function automatic int note_len(input int i);
        return (int'(rom[i][DUR_W+NOTE_W-1:NOTE_W]) + 1) * TICK_DIV;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] expv);
        total++;
        assert (got === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s got={emp,cue,nota,nv,rep,fin}=%b required=%b", name, got, expv);
        end
    endtask

    task automatic push(input logic e, input logic c, input logic [NOTE_W-1:0] n,
                        input logic nv, input logic r, input logic f);
        exp_q.push_back({e, c, n, nv, r, f});
    endtask

    task automatic push_start();
        push(1'b1, 1'b0, cur_nota, 1'b0, 1'b1, 1'b0);
        push(1'b0, 1'b0, cur_nota, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_load();
        push(1'b0, 1'b0, cur_nota, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_play(input logic [NOTE_W-1:0] n, input int k);
        cur_nota = n;
        for (int i = 0; i < k; i++) push(1'b0, 1'b0, n, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic push_paused(input int k);
        for (int i = 0; i < k; i++) push(1'b0, 1'b0, cur_nota, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_step_wait();
        push(1'b0, 1'b1, cur_nota, 1'b0, 1'b1, 1'b0);
        push(1'b0, 1'b0, cur_nota, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_fin();
        push(1'b0, 1'b0, cur_nota, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_idle(input int k);
        for (int i = 0; i < k; i++) push(1'b0, 1'b0, cur_nota, 1'b0, 1'b0, 1'b0);
    endtask

    // Whole song from the START cycle through the fin pulse
    task automatic push_song(input int lim);
        push_start();
        for (int i = 0; i <= lim; i++) begin
            push_load();
            push_play(rom[i][NOTE_W-1:0], note_len(i));
            push_step_wait();
        end
        push_fin();
    endtask

    task automatic load_song(input int lim, input int dmax);
        for (int i = 0; i < 4; i++) begin
            rom[i] = {DUR_W'($urandom_range(0, dmax)), NOTE_W'($urandom_range(1, 31))};
        end
        limite = ADDR_W'(lim);
    endtask

    // Each step samples mid-cycle; pulses set afterwards are seen at the next rising edge
    task automatic run_queue(input string name);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            e = exp_q.pop_front();
            check(name, outs(), e);
            play  = 1'b0;
            stop  = 1'b0;
            pausa = 1'b0;
        end
    endtask

    initial begin
        int p, h, d, tot, k, lim;
        for (int i = 0; i < 4; i++) rom[i] = '0;

        repeat (3) @(negedge clock);
        check("reset_values", outs(), '0);
        reset = 1'b0;
        push_idle(3);
        run_queue("idle_after_reset");

        // durations 0,1,2 in ROM order
        load_song(2, 0);
        rom[1][DUR_W+NOTE_W-1:NOTE_W] = DUR_W'(1);
        rom[2][DUR_W+NOTE_W-1:NOTE_W] = DUR_W'(2);
        play = 1'b1;
        push_song(2);
        push_idle(2);
        run_queue("song_dur012");

        // single-note song
        load_song(0, 3);
        play = 1'b1;
        push_song(0);
        push_idle(1);
        run_queue("single_note");

        for (int r = 0; r < 3; r++) begin
            lim = $urandom_range(0, 2);
            load_song(lim, 3);
            play = 1'b1;
            push_song(lim);
            push_idle(1);
            run_queue("random_song");
        end

        // repetir: note 0 replays after the last note, then stop
        load_song(2, 2);
        repetir = 1'b1;
        play = 1'b1;
        push_start();
        for (int i = 0; i <= 2; i++) begin
            push_load();
            push_play(rom[i][NOTE_W-1:0], note_len(i));
            push_step_wait();
        end
        push_start();
        push_load();
        k = $urandom_range(1, note_len(0));
        push_play(rom[0][NOTE_W-1:0], k);
        run_queue("repeat_loop");
        stop = 1'b1;
        push_idle(2);
        run_queue("repeat_stop");
        repetir = 1'b0;

        // pause two cycles into a dur=1 note for 20 cycles
        load_song(0, 0);
        rom[0][DUR_W+NOTE_W-1:NOTE_W] = DUR_W'(1);
        play = 1'b1;
        push_start();
        push_load();
        push_play(rom[0][NOTE_W-1:0], 3);
        run_queue("pause_before");
        pausa = 1'b1;
        push_paused(20);
        run_queue("pause_hold");
        pausa = 1'b1;
        push_play(rom[0][NOTE_W-1:0], 5);
        push_step_wait();
        push_fin();
        run_queue("pause_resume");

        // random pause points that avoid the beat-tick cycle
        for (int r = 0; r < 2; r++) begin
            d = $urandom_range(0, 3);
            load_song(0, 0);
            rom[0][DUR_W+NOTE_W-1:NOTE_W] = DUR_W'(d);
            tot = (d + 1) * TICK_DIV;
            do p = $urandom_range(0, tot - 2); while (p % TICK_DIV == TICK_DIV - 1);
            h = $urandom_range(1, 20);
            play = 1'b1;
            push_start();
            push_load();
            push_play(rom[0][NOTE_W-1:0], p + 1);
            run_queue("rpause_before");
            pausa = 1'b1;
            push_paused(h);
            run_queue("rpause_hold");
            pausa = 1'b1;
            push_play(rom[0][NOTE_W-1:0], tot - (p + 1));
            push_step_wait();
            push_fin();
            run_queue("rpause_resume");
        end

        // play during note 1 restarts from note 0
        load_song(2, 2);
        play = 1'b1;
        push_start();
        push_load();
        push_play(rom[0][NOTE_W-1:0], note_len(0));
        push_step_wait();
        push_load();
        push_play(rom[1][NOTE_W-1:0], $urandom_range(1, note_len(1)));
        run_queue("restart_before");
        play = 1'b1;
        push_song(2);
        push_idle(1);
        run_queue("restart_song");

        // asynchronous reset in the middle of a note
        load_song(2, 3);
        play = 1'b1;
        push_start();
        push_load();
        push_play(rom[0][NOTE_W-1:0], 2);
        run_queue("reset_before");
        #2 reset = 1'b1;
        #1 check("reset_async", outs(), '0);
        cur_nota = '0;
        @(negedge clock);
        reset = 1'b0;
        push_idle(5);
        run_queue("idle_after_midreset");

        load_song(0, 1);
        play = 1'b1;
        push_song(0);
        push_idle(1);
        run_queue("song_after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
